shift_register_univ: RTL
========================

SHIFT_REGISTER_UNIV -- requirements
Module: shift_register_univ

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; SHALL be >= 2.
REQ-002 Parameter RESET_VALUE, default 0, WIDTH-bit value loaded into q by clr.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-004 Port clr  input  1  reset, synchronous, active-high; SHALL take effect only at a rising clk edge.
REQ-005 Port ena  input  1  operation enable; 0 SHALL freeze all state.
REQ-006 Port mode  input  3  operation select (encoding in REQ-011).
REQ-007 Port d  input  WIDTH  parallel load data.
REQ-008 Port sin_r  input  1  serial bit entering at LSB on shift-left.
REQ-009 Port sin_l  input  1  serial bit entering at MSB on logical shift-right.
REQ-010 Port q  output  WIDTH  register contents; co  output  1  registered shift-out/carry bit; zero  output  1  combinational, 1 iff q == 0.

Function
REQ-011 mode encoding SHALL be: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CNT.
REQ-012 Priority at each rising edge SHALL be: clr, then ena, then mode.
REQ-013 ena=0 and clr=0: q and co SHALL retain their values regardless of mode, d, sin_l, sin_r.
REQ-014 HOLD: q and co unchanged.
REQ-015 LOAD: q <= d; co <= 0.
REQ-016 SHL: q <= {q[WIDTH-2:0], sin_r}; co <= q[WIDTH-1].
REQ-017 SHR: q <= {sin_l, q[WIDTH-1:1]}; co <= q[0].
REQ-018 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; co <= q[WIDTH-1]; sin_r ignored.
REQ-019 ROR: q <= {q[0], q[WIDTH-1:1]}; co <= q[0]; sin_l ignored.
REQ-020 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; co <= q[0]; sin_l ignored.
REQ-021 CNT: q <= q + 1 modulo 2^WIDTH; co <= 1 iff the increment wraps (q was all ones), else 0.
REQ-022 Latency: every operation SHALL be visible on q and co exactly one clk cycle after the enabling edge; no multi-cycle operations.
REQ-023 zero SHALL be derived from the current q without additional register stage (same-cycle as q).
REQ-024 All shift/rotate/count results SHALL be computed from q sampled before the edge (no same-edge chaining).
REQ-025 d, sin_l, sin_r SHALL affect state only in LOAD, SHR, SHL respectively.
REQ-026 Mode change between consecutive cycles SHALL need no idle cycle; each cycle independently applies its own mode.
REQ-027 No X-propagation: all outputs SHALL be defined from the first clr edge onward.

Reset
REQ-028 clr=1 at a rising edge SHALL set q <= RESET_VALUE and co <= 0, independent of ena, mode and data inputs.
REQ-029 clr asserted mid-sequence (e.g. during CNT run) SHALL abort it; next cycle with clr=0, ena=1 SHALL operate on RESET_VALUE.
REQ-030 clr deasserted SHALL resume normal operation at the very next rising edge, no extra latency.
REQ-031 Before the first clr edge q and co are undefined; benches SHALL apply clr for >= 1 cycle at start.

Verification (WIDTH=8, RESET_VALUE=0 unless stated)
REQ-032 clr=1, ena=0, mode=LOAD, d=0xA5 for one edge -> q=0x00, co=0, zero=1; with RESET_VALUE=0x3C -> q=0x3C, zero=0.
REQ-033 LOAD 0x81 then ROL -> q=0x03, co=1; then ROR -> q=0x81, co=1; then SHR with sin_l=0 -> q=0x40, co=1.
REQ-034 LOAD 0x80 then ASR -> q=0xC0, co=0; then SHL with sin_r=1 -> q=0x81, co=1.
REQ-035 LOAD 0xFE then CNT x2 -> q=0xFF co=0, then q=0x00 co=1, zero=1; third CNT -> q=0x01, co=0.
REQ-036 LOAD 0x5A, then ena=0 with mode cycling all 8 codes and random d/sin -> q=0x5A, co=0 throughout; then clr=1 with ena=1, mode=CNT -> q=0x00, co=0.
REQ-037 Random mode/data/ena/clr stream >= 10000 cycles checked each cycle against a reference model of REQ-011..REQ-028.

Source files
------------

// File: rtl/shift_register_univ.sv
// Universal shift register: hold, parallel load, logical/arithmetic shifts,
// rotates and increment, with a registered carry-out and a live zero flag.
module shift_register_univ #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ena,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             zero
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CNT  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;
  logic [WIDTH:0]   inc_sum;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);
  // Carry of the increment lands in the extra top bit.
  assign inc_sum  = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    q_d  = q_q;
    co_d = co_q;
    case (mode_sel)
      MODE_HOLD: begin
        q_d  = q_q;
        co_d = co_q;
      end
      MODE_LOAD: begin
        q_d  = d;
        co_d = 1'b0;
      end
      MODE_SHL: begin
        q_d  = {q_q[WIDTH-2:0], sin_r};
        co_d = q_q[WIDTH-1];
      end
      MODE_SHR: begin
        q_d  = {sin_l, q_q[WIDTH-1:1]};
        co_d = q_q[0];
      end
      MODE_ROL: begin
        q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        co_d = q_q[WIDTH-1];
      end
      MODE_ROR: begin
        q_d  = {q_q[0], q_q[WIDTH-1:1]};
        co_d = q_q[0];
      end
      MODE_ASR: begin
        q_d  = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        co_d = q_q[0];
      end
      MODE_CNT: begin
        q_d  = inc_sum[WIDTH-1:0];
        co_d = inc_sum[WIDTH];
      end
      default: begin
        q_d  = q_q;
        co_d = co_q;
      end
    endcase
  end

  // clr wins over ena, which wins over the selected operation.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_q  <= RESET_VALUE;
      co_q <= 1'b0;
    end else if (ena) begin
      q_q  <= q_d;
      co_q <= co_d;
    end
  end

  assign q    = q_q;
  assign co   = co_q;
  assign zero = (q_q == '0);

endmodule
